// File: rtl/io_mux_pkg.sv
// Shared constants and types for the io_mux pin multiplexer:
// register offsets, per-pin state encoding and function indices.
package io_mux_pkg;

    localparam logic [7:0] SEL_BASE   = 8'h00;
    localparam logic [7:0] LOCK_OFF   = 8'h40;
    localparam logic [7:0] STATUS_OFF = 8'h44;
    localparam logic [7:0] PADIN_OFF  = 8'h48;

    typedef enum logic {
        STABLE = 1'b0,
        GUARD  = 1'b1
    } pin_state_e;

    localparam int unsigned FUNC_GPIO = 0;
    localparam int unsigned FUNC_ALT1 = 1;
    localparam int unsigned FUNC_ALT2 = 2;
    localparam int unsigned FUNC_ALT3 = 3;

    // Width of a function-select field; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_mux_pin.sv
// One muxed pad: guarded function switching, output mux and input synchroniser.
module io_mux_pin
    import io_mux_pkg::*;
#(
    parameter int unsigned NUM_FUNCS    = 4,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    localparam int unsigned FW          = sel_width(NUM_FUNCS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_FUNCS-1:0] i_func_out,
    input  logic [NUM_FUNCS-1:0] i_func_oe,
    output logic [NUM_FUNCS-1:0] o_func_in,
    input  logic                 i_pad_in,
    output logic                 o_pad_out,
    output logic                 o_pad_oe,
    input  logic                 i_sel_we,
    input  logic [31:0]          i_sel_wdata,
    output logic [FW-1:0]        o_pending,
    output logic                 o_guard,
    output logic                 o_sync
);

    pin_state_e             r_state;
    logic [7:0]             r_cnt;
    logic [FW-1:0]          r_active;
    logic [FW-1:0]          r_pend;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_valid;
    logic [FW-1:0]          w_new;

    assign w_new   = i_sel_wdata[FW-1:0];
    // Range check uses the whole word so high garbage bits cannot alias a valid function.
    assign w_valid = i_sel_we && (i_sel_wdata < 32'(NUM_FUNCS)) && (w_new != r_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= STABLE;
            r_cnt    <= '0;
            r_active <= '0;
            r_pend   <= '0;
        end else begin
            case (r_state)
                STABLE: begin
                    if (w_valid) begin
                        r_pend <= w_new;
                        if (GUARD_CYCLES == 0) begin
                            r_active <= w_new;
                        end else begin
                            r_cnt   <= 8'(GUARD_CYCLES);
                            r_state <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (w_valid) begin
                        r_pend <= w_new;
                        r_cnt  <= 8'(GUARD_CYCLES);
                    end else if (r_cnt == 8'd1) begin
                        r_active <= r_pend;
                        r_cnt    <= '0;
                        r_state  <= STABLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= STABLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_in};
        end
    end

    // Inactive functions see idle-high so UART/I2C receivers stay quiet.
    always_comb begin
        o_pad_out = 1'b0;
        o_pad_oe  = 1'b0;
        o_func_in = '1;
        if (r_state == STABLE) begin
            o_pad_out           = i_func_out[r_active];
            o_pad_oe            = i_func_oe[r_active];
            o_func_in[r_active] = r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pending = r_pend;
    assign o_guard   = (r_state == GUARD);
    assign o_sync    = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/io_mux.sv
// Memory-mapped pin multiplexer: bus decode, LOCK register, read mux and per-pin instances.
module io_mux
    import io_mux_pkg::*;
#(
    parameter logic [31:0] IO_MUX_BASE_ADDR = 32'h4000_5000,
    parameter int unsigned NUM_PINS         = 8,
    parameter int unsigned NUM_FUNCS        = 4,
    parameter int unsigned GUARD_CYCLES     = 4,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_wdata,
    input  logic                          mem_we,
    input  logic                          mem_re,
    output logic [31:0]                   mem_rdata,
    input  logic [NUM_FUNCS*NUM_PINS-1:0] func_out,
    input  logic [NUM_FUNCS*NUM_PINS-1:0] func_oe,
    output logic [NUM_FUNCS*NUM_PINS-1:0] func_in,
    input  logic [NUM_PINS-1:0]           pad_in,
    output logic [NUM_PINS-1:0]           pad_out,
    output logic [NUM_PINS-1:0]           pad_oe
);

    localparam int unsigned FW = sel_width(NUM_FUNCS);

    logic                                 w_hit;
    logic                                 w_wr;
    logic [7:0]                           w_off;
    logic                                 r_lock;
    logic [NUM_PINS-1:0]                  w_pin_we;
    logic [NUM_PINS-1:0]                  w_guard;
    logic [NUM_PINS-1:0]                  w_sync;
    logic [NUM_PINS-1:0][FW-1:0]          w_pend;
    logic [NUM_PINS-1:0][NUM_FUNCS-1:0]   w_fout;
    logic [NUM_PINS-1:0][NUM_FUNCS-1:0]   w_foe;
    logic [NUM_PINS-1:0][NUM_FUNCS-1:0]   w_fin;

    assign w_off = mem_addr[7:0];
    assign w_hit = (mem_addr[31:8] == IO_MUX_BASE_ADDR[31:8]) && (mem_addr[1:0] == 2'b00);
    assign w_wr  = mem_we && w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (w_wr && (w_off == LOCK_OFF) && mem_wdata[0]) begin
            r_lock <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        assign w_pin_we[p] = w_wr && !r_lock && (w_off == SEL_BASE + 8'(4 * p));

        // Regroup the function-major bus into per-pin vectors.
        for (genvar f = 0; f < NUM_FUNCS; f++) begin : g_func
            assign w_fout[p][f]           = func_out[f*NUM_PINS+p];
            assign w_foe[p][f]            = func_oe[f*NUM_PINS+p];
            assign func_in[f*NUM_PINS+p]  = w_fin[p][f];
        end

        io_mux_pin #(
            .NUM_FUNCS    (NUM_FUNCS),
            .GUARD_CYCLES (GUARD_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_pin (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_func_out  (w_fout[p]),
            .i_func_oe   (w_foe[p]),
            .o_func_in   (w_fin[p]),
            .i_pad_in    (pad_in[p]),
            .o_pad_out   (pad_out[p]),
            .o_pad_oe    (pad_oe[p]),
            .i_sel_we    (w_pin_we[p]),
            .i_sel_wdata (mem_wdata),
            .o_pending   (w_pend[p]),
            .o_guard     (w_guard[p]),
            .o_sync      (w_sync[p])
        );
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_re && w_hit) begin
            case (w_off)
                LOCK_OFF:   mem_rdata[0]          = r_lock;
                STATUS_OFF: mem_rdata[NUM_PINS-1:0] = w_guard;
                PADIN_OFF:  mem_rdata[NUM_PINS-1:0] = w_sync;
                default: begin
                    for (int unsigned p = 0; p < NUM_PINS; p++) begin
                        if (w_off == SEL_BASE + 8'(4 * p)) begin
                            mem_rdata[FW-1:0] = w_pend[p];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_mux.sv
// Directed self-checking bench for io_mux with 8 pins, 4 functions, 4-cycle guard.
module tb_io_mux;

    localparam logic [31:0] BASE   = 32'h4000_5000;
    localparam logic [31:0] LOCK   = BASE + 32'h40;
    localparam logic [31:0] STATUS = BASE + 32'h44;
    localparam logic [31:0] PADIN  = BASE + 32'h48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [31:0] func_out;
    logic [31:0] func_oe;
    logic [31:0] func_in;
    logic [7:0]  pad_in;
    logic [7:0]  pad_out;
    logic [7:0]  pad_oe;

    int vectors = 0;
    int errors  = 0;

    io_mux #(
        .IO_MUX_BASE_ADDR (BASE),
        .NUM_PINS         (8),
        .NUM_FUNCS        (4),
        .GUARD_CYCLES     (4),
        .SYNC_STAGES      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .func_out  (func_out),
        .func_oe   (func_oe),
        .func_in   (func_in),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(posedge clk);
        #1;
        mem_we   = 1'b0;
        mem_addr = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        mem_addr = a;
        mem_re   = 1'b1;
        #1;
        d        = mem_rdata;
        mem_re   = 1'b0;
        mem_addr = '0;
    endtask

    function automatic logic [31:0] sel(input int p);
        return BASE + 32'(4 * p);
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (pad_out !== 8'hFF) begin errors++; $display("FAIL rst_pad_out: got %h expected ff", pad_out); end
        vectors++; if (pad_oe !== 8'hFF) begin errors++; $display("FAIL rst_pad_oe: got %h expected ff", pad_oe); end
        vectors++; if (func_in !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_func_in: got %h expected ffffffff", func_in); end
        mem_addr = BASE; mem_re = 1'b0; #1;
        vectors++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata_idle: got %h expected 0", mem_rdata); end
        for (int p = 0; p < 8; p++) begin
            rd(sel(p), d);
            vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_sel%0d: got %h expected 0", p, d); end
        end
        rd(LOCK, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_lock: got %h expected 0", d); end
        @(negedge clk);
        rst_n = 1'b1;
        rd(STATUS, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", d); end
    endtask

    task automatic test_guard;
        logic [31:0] d;
        wr(sel(3), 32'd2);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (pad_oe !== 8'hF7 || pad_out !== 8'hF7) begin errors++; $display("FAIL guard_pad c%0d: got oe=%h out=%h expected oe=f7 out=f7", i, pad_oe, pad_out); end
            rd(STATUS, d);
            vectors++; if (d !== 32'h08) begin errors++; $display("FAIL guard_status c%0d: got %h expected 08", i, d); end
            @(posedge clk); #1;
        end
        vectors++; if (pad_oe !== 8'hFF || pad_out !== 8'hFF) begin errors++; $display("FAIL guard_done_pad: got oe=%h out=%h expected oe=ff out=ff", pad_oe, pad_out); end
        rd(STATUS, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL guard_done_status: got %h expected 0", d); end
        rd(sel(3), d);
        vectors++; if (d !== 32'd2) begin errors++; $display("FAIL guard_sel3: got %h expected 2", d); end
        func_out[2*8+3] = 1'b0; #1;
        vectors++; if (pad_out !== 8'hF7) begin errors++; $display("FAIL guard_follow_f2: got %h expected f7", pad_out); end
        func_out[2*8+3] = 1'b1; #1;
    endtask

    task automatic test_restart;
        logic [31:0] d;
        wr(sel(3), 32'd3);
        vectors++; if (pad_oe[3] !== 1'b0) begin errors++; $display("FAIL restart_pre0: got %b expected 0", pad_oe[3]); end
        @(posedge clk); #1;
        vectors++; if (pad_oe[3] !== 1'b0) begin errors++; $display("FAIL restart_pre1: got %b expected 0", pad_oe[3]); end
        wr(sel(3), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd(STATUS, d);
            vectors++; if (d !== 32'h08 || pad_oe[3] !== 1'b0) begin errors++; $display("FAIL restart_guard c%0d: got status=%h oe3=%b expected status=08 oe3=0", i, d, pad_oe[3]); end
            @(posedge clk); #1;
        end
        vectors++; if (pad_oe !== 8'hFF || pad_out !== 8'hF7) begin errors++; $display("FAIL restart_f1: got oe=%h out=%h expected oe=ff out=f7", pad_oe, pad_out); end
        rd(sel(3), d);
        vectors++; if (d !== 32'd1) begin errors++; $display("FAIL restart_sel3: got %h expected 1", d); end
    endtask

    task automatic test_padin;
        logic [31:0] d;
        wr(sel(5), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        pad_in[5] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (func_in !== 32'hFFFF_DFFF) begin errors++; $display("FAIL padin_low: got %h expected ffffdfff", func_in); end
        rd(PADIN, d);
        vectors++; if (d !== 32'hDF) begin errors++; $display("FAIL padin_reg_low: got %h expected df", d); end
        @(negedge clk);
        pad_in[5] = 1'b1;
        @(posedge clk); #1;
        vectors++; if (func_in[13] !== 1'b0) begin errors++; $display("FAIL padin_lat1: got %b expected 0", func_in[13]); end
        @(posedge clk); #1;
        vectors++; if (func_in[13] !== 1'b1 || func_in[5] !== 1'b1) begin errors++; $display("FAIL padin_lat2: got f1=%b f0=%b expected 1 1", func_in[13], func_in[5]); end
        rd(PADIN, d);
        vectors++; if (d !== 32'hFF) begin errors++; $display("FAIL padin_reg_high: got %h expected ff", d); end
    endtask

    task automatic test_invalid_lock;
        logic [31:0] d;
        wr(sel(0), 32'd5);
        rd(sel(0), d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL inv_sel0_5: got %h expected 0", d); end
        wr(sel(0), 32'h101);
        rd(STATUS, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL inv_highbits_status: got %h expected 0", d); end
        wr(sel(0), 32'd0);
        rd(STATUS, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL inv_same_status: got %h expected 0", d); end
        wr(LOCK, 32'd0);
        rd(LOCK, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL lock_zero: got %h expected 0", d); end
        wr(LOCK, 32'd1);
        rd(LOCK, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL lock_set: got %h expected 1", d); end
        wr(sel(0), 32'd1);
        rd(sel(0), d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL lock_sel0: got %h expected 0", d); end
        rd(STATUS, d);
        vectors++; if (d !== 32'h0 || pad_oe[0] !== 1'b1) begin errors++; $display("FAIL lock_status: got %h oe0=%b expected 0 1", d, pad_oe[0]); end
        wr(LOCK, 32'd0);
        rd(LOCK, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL lock_sticky: got %h expected 1", d); end
        rd(BASE + 32'h80, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped: got %h expected 0", d); end
    endtask

    task automatic test_reset_mid_guard;
        logic [31:0] d;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rd(LOCK, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL mid_lock_cleared: got %h expected 0", d); end
        wr(sel(2), 32'd3);
        rd(STATUS, d);
        vectors++; if (d !== 32'h04) begin errors++; $display("FAIL mid_status_guard: got %h expected 04", d); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        rd(STATUS, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL mid_status_reset: got %h expected 0", d); end
        vectors++; if (pad_oe !== 8'hFF || pad_out !== 8'hFF) begin errors++; $display("FAIL mid_pads: got oe=%h out=%h expected ff ff", pad_oe, pad_out); end
        rd(sel(2), d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL mid_sel2: got %h expected 0", d); end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd(STATUS, d);
        vectors++; if (d !== 32'h0 || pad_oe !== 8'hFF) begin errors++; $display("FAIL mid_after: got status=%h oe=%h expected 0 ff", d, pad_oe); end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        pad_in    = 8'hFF;
        func_out  = {8'h00, 8'h3C, 8'h52, 8'hFF};
        func_oe   = {8'h00, 8'hFF, 8'hFF, 8'hFF};
        test_reset;
        test_guard;
        test_restart;
        test_padin;
        test_invalid_lock;
        test_reset_mid_guard;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
